inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Decoupled instruction-fetch front end replacing the single-cycle inst_sram path.
- Generates sequential fetch PCs and issues requests on an SRAM-like handshake interface (req/addr_ok/data_ok) with up to MAX_OUTSTANDING in-flight requests.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO feeding the IFID stage under a valid/ready handshake.
- Handles redirects (branch, jump, exception, eret) by flushing the queue and discarding stale responses.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
MAX_OUTSTANDING, 2, max issued-but-unanswered requests; 1..DEPTH
RESET_PC, 32'hBFC00000, first fetch address after reset

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address
inst_req  out  1  request valid
inst_wr  out  1  tied 0
inst_size  out  2  tied 2'b10 (word)
inst_addr  out  32  request address (virtual; MMU is external)
inst_addr_ok  in  1  request accepted this cycle when inst_req=1
inst_rdata  in  32  response data
inst_data_ok  in  1  response valid; responses return in order
id_valid  out  1  head entry valid
id_ready  in  1  IFID accepts head entry
id_pc  out  32  PC of head entry
id_instr  out  32  instruction of head entry
id_adel  out  1  head entry is a fetch address error (PC[1:0]!=0)

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, inst_req=0, id_valid=0, id_pc=0, id_instr=0, id_adel=0.
- Issue condition: inst_req=1 when !redirect_valid, outstanding<MAX_OUTSTANDING, (fifo_count+outstanding)<DEPTH, fetch_pc[1:0]==0, and no pending AdEL entry. inst_addr=fetch_pc.
- Once inst_req=1, inst_req and inst_addr hold stable until inst_addr_ok, unless redirect_valid is asserted.
- On inst_req&&inst_addr_ok: outstanding+1, fetch_pc+=4 (wraps modulo 2^32).
- On inst_data_ok: if discard>0, decrement discard and drop the data. Otherwise push {fetch-order PC, inst_rdata, adel=0} and decrement outstanding. The in-flight PC queue is MAX_OUTSTANDING deep.
- Simultaneous accept and response in the same cycle: outstanding is unchanged.
- Misaligned fetch_pc: no bus request. Once outstanding==0 and the FIFO has space, push a single entry {fetch_pc, 32'h0, adel=1} and stop issuing until redirect.
- Pop: id_valid&&id_ready pops the head. Push and pop in the same cycle are allowed when full (pop frees the slot). FIFO outputs are registered from storage; the head is visible the cycle after push (1-cycle push-to-id_valid latency). Bus-to-ID minimum latency is addr_ok, then data_ok, then +1 cycle.
- Redirect (has priority over everything):
  - FIFO empties next cycle.
  - fetch_pc<=redirect_pc.
  - discard<=discard+outstanding, minus 1 if a non-discarded data_ok arrives the same cycle.
  - outstanding<=0. A request accepted in the redirect cycle is counted into discard.
  - id_valid=0 from the next cycle.
- A new request may issue while discard>0. Responses are in order, so discarded ones always arrive first.
- Reset mid-transaction: the bus agent is reset together with this block, so pending responses are not tracked.
- Full: no issue while fifo_count+outstanding==DEPTH. Empty: id_valid=0.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs perf_fetch_cnt[31:0] (accepted requests), perf_discard_cnt[31:0] (dropped responses) and perf_stall_cnt[31:0] (cycles with id_ready=1 and id_valid=0). All three reset to 0 and wrap.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package (CPU_Defines): typedef FetchEntry {pc[31:0], instr[31:0], adel}, constant RESET_PC default, typedef for the SRAM-like size encoding.
- Sub-module sync_fifo #(WIDTH, DEPTH) with push/pop/flush/full/empty/count. It is instantiated for the instruction FIFO and for the in-flight PC queue.

Test Plan:
- Reset, then addr_ok held 1 and data_ok one cycle after each accept with id_ready=1: PCs BFC00000, BFC00004, BFC00008 appear in order; at most 2 outstanding.
- id_ready=0 with DEPTH=4: exactly 4 requests issued, inst_req=0 afterwards. Raising id_ready pops one and restarts issue the same cycle.
- Two requests outstanding, then redirect_valid to 80000100: next two data_ok are dropped; first id_pc=80000100 with the correct instr.
- Redirect to 80000102: no inst_req. One entry id_adel=1, id_pc=80000102. Redirect to 80000200 resumes fetch.
- Hold inst_addr_ok=0 for 5 cycles: inst_req and inst_addr stable throughout. Push and pop in the same cycle when full: count stays at 4.
- With FETCH_PERF_EN, the redirect scenario above: perf_discard_cnt=2, perf_fetch_cnt equals the number of accepted requests.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared CPU defines for the fetch front end (entry layout, reset PC, SRAM size codes).
package inst_fetch_queue_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;
  typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10} sram_size_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// sync_fifo: register-array FIFO with flush; a pop frees the slot for a same-cycle push when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign w_pop = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign empty = r_cnt == '0;
  assign full = r_cnt == CW'(DEPTH);
  assign count = r_cnt;
  assign dout = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr == AW'(DEPTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == AW'(DEPTH - 1) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= din;
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: decoupled fetch front end with in-flight PC queue and instruction FIFO.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        id_adel
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  fetch_entry_t w_push_entry, w_head;
  logic [31:0] r_fetch_pc, w_pcq_head;
  logic [7:0] r_discard;
  logic r_adel_done;
  logic [CW-1:0] w_fifo_cnt;
  logic [OW-1:0] w_outst;
  logic [CW:0] w_used;
  logic w_fifo_full, w_fifo_empty, w_pcq_full, w_pcq_empty;
  logic w_accept, w_keep, w_drop, w_misaligned, w_adel_push, w_pop, w_push;
  assign w_pop = id_valid && id_ready;
  assign w_used = (CW + 1)'(w_fifo_cnt) + (CW + 1)'(w_outst);
  assign w_misaligned = r_fetch_pc[1:0] != 2'b00;
  // A same-cycle pop already frees a slot, so issue can resume without a bubble.
  assign inst_req = !rst && !redirect_valid && !w_misaligned && !w_pcq_full && w_used < (CW + 1)'(DEPTH) + (CW + 1)'(w_pop);
  assign inst_wr = 1'b0;
  assign inst_size = SIZE_WORD;
  assign inst_addr = r_fetch_pc;
  assign w_accept = inst_req && inst_addr_ok;
  assign w_drop = inst_data_ok && (r_discard != '0 || redirect_valid);
  assign w_keep = inst_data_ok && !w_drop;
  assign w_adel_push = w_misaligned && !r_adel_done && w_pcq_empty && !w_fifo_full && !redirect_valid;
  assign w_push = w_keep || w_adel_push;
  assign w_push_entry = w_adel_push ? fetch_entry_t'{pc: r_fetch_pc, instr: 32'h0, adel: 1'b1} : fetch_entry_t'{pc: w_pcq_head, instr: inst_rdata, adel: 1'b0};
  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(w_push), .pop(w_pop), .flush(redirect_valid), .din(w_push_entry),
    .dout(w_head), .full(w_fifo_full), .empty(w_fifo_empty), .count(w_fifo_cnt)
  );
  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pcq (
    .clk(clk), .rst(rst), .push(w_accept), .pop(w_keep), .flush(redirect_valid), .din(r_fetch_pc),
    .dout(w_pcq_head), .full(w_pcq_full), .empty(w_pcq_empty), .count(w_outst)
  );
  assign id_valid = !w_fifo_empty;
  assign id_pc = id_valid ? w_head.pc : '0;
  assign id_instr = id_valid ? w_head.instr : '0;
  assign id_adel = id_valid && w_head.adel;
  // In-order responses: everything in flight at a redirect is stale and arrives first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_discard <= '0;
      r_adel_done <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_discard <= r_discard + 8'(w_outst) - 8'(inst_data_ok);
      r_adel_done <= 1'b0;
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_drop) r_discard <= r_discard - 8'd1;
      if (w_adel_push) r_adel_done <= 1'b1;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_discard_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(w_accept);
      perf_discard_cnt <= perf_discard_cnt + 32'(w_drop);
      perf_stall_cnt <= perf_stall_cnt + 32'(id_ready && !id_valid);
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: bus agent with configurable response latency plus an in-order ID scoreboard.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;
  logic clk = 1'b0, rst = 1'b1, redirect_valid = 1'b0, id_ready = 1'b1;
  logic [31:0] redirect_pc = '0, inst_rdata = '0;
  logic inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic inst_req, inst_wr, id_valid, id_adel;
  logic [1:0] inst_size;
  logic [31:0] inst_addr, id_pc, id_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_discard_cnt, perf_stall_cnt;
`endif
  typedef struct { logic [31:0] addr; int cyc; } req_t;
  req_t bus_q[$];
  fetch_entry_t sb_q[$];
  fetch_entry_t exp_e;
  int n_checks = 0, n_fail = 0, cyc = 0, lat = 1, n_acc = 0, n_tot = 0, peak = 0;
  bit aok_en = 1'b1;

  inst_fetch_queue dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_discard_cnt(perf_discard_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .id_adel(id_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pop(output logic [31:0] pc, output logic [31:0] ins, output logic adel);
    int k = 0;
    while (!(id_valid && id_ready) && k < 100) begin
      step(1);
      k++;
    end
    check("pop_timeout", 32'(k < 100), 32'd1);
    pc = id_pc;
    ins = id_instr;
    adel = id_adel;
    step(1);
  endtask

  // Bus agent and ID monitor: inputs for the next rising edge are decided here.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bus_q.delete();
      inst_data_ok = 1'b0;
      inst_addr_ok = 1'b0;
    end else begin
      if (bus_q.size() > peak) peak = bus_q.size();
      inst_data_ok = 1'b0;
      if (bus_q.size() > 0 && bus_q[0].cyc + lat <= cyc) begin
        inst_data_ok = 1'b1;
        inst_rdata = hash(bus_q[0].addr);
        void'(bus_q.pop_front());
      end
      inst_addr_ok = aok_en;
      if (inst_req && aok_en) begin
        bus_q.push_back('{inst_addr, cyc});
        sb_q.push_back('{pc: inst_addr, instr: hash(inst_addr), adel: 1'b0});
        n_acc++;
        n_tot++;
      end
      if (id_valid && id_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 32'd1);
        else begin
          exp_e = sb_q.pop_front();
          check("sb_pc", id_pc, exp_e.pc);
          check("sb_instr", id_instr, exp_e.instr);
          check("sb_adel", 32'(id_adel), 32'(exp_e.adel));
        end
      end
    end
  end

  initial begin
    logic [31:0] pc, ins, a0;
    logic adel;
    int k;
`ifdef FETCH_PERF_EN
    logic [31:0] d0;
`endif
    step(3);
    check("rst_inst_req", 32'(inst_req), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_adel", 32'(id_adel), 32'd0);
    check("inst_wr", 32'(inst_wr), 32'd0);
    check("inst_size", 32'(inst_size), 32'd2);
    rst = 1'b0;
    wait_pop(pc, ins, adel);
    check("seq_pc0", pc, 32'hBFC00000);
    check("seq_instr0", ins, hash(32'hBFC00000));
    wait_pop(pc, ins, adel);
    check("seq_pc1", pc, 32'hBFC00004);
    wait_pop(pc, ins, adel);
    check("seq_pc2", pc, 32'hBFC00008);
    lat = 3;
    step(1);
    peak = 0;
    step(20);
    check("peak_outstanding", peak, 32'd2);
    // Fill with the consumer stalled
    id_ready = 1'b0;
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000000;
    step(1);
    redirect_valid = 1'b0;
    sb_q.delete();
    n_acc = 0;
    step(15);
    check("full_accepts", n_acc, 32'd4);
    check("full_no_req", 32'(inst_req), 32'd0);
    check("full_id_valid", 32'(id_valid), 32'd1);
    check("full_head_pc", id_pc, 32'h80000000);
    id_ready = 1'b1;
    #1;
    check("pop_restarts_req", 32'(inst_req), 32'd1);
    step(1);
    id_ready = 1'b0;
    step(10);
    check("refill_accepts", n_acc, 32'd5);
    check("refill_no_req", 32'(inst_req), 32'd0);
    check("refill_head_pc", id_pc, 32'h80000004);
    id_ready = 1'b1;
    step(5);
    // Redirect with two requests in flight
    lat = 3;
    step(10);
    k = 0;
    while (bus_q.size() != 2 && k < 20) begin
      step(1);
      k++;
    end
    check("two_outstanding", bus_q.size(), 32'd2);
`ifdef FETCH_PERF_EN
    d0 = perf_discard_cnt;
`endif
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000100;
    #1;
    check("redir_no_req", 32'(inst_req), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    sb_q.delete();
    wait_pop(pc, ins, adel);
    check("redir_pc", pc, 32'h80000100);
    check("redir_instr", ins, hash(32'h80000100));
`ifdef FETCH_PERF_EN
    check("perf_discard", perf_discard_cnt - d0, 32'd2);
    check("perf_fetch", perf_fetch_cnt, n_tot);
`endif
    // Misaligned redirect produces a single AdEL entry
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000102;
    step(1);
    redirect_valid = 1'b0;
    sb_q.delete();
    sb_q.push_back('{pc: 32'h80000102, instr: 32'h0, adel: 1'b1});
    #1;
    check("adel_no_req", 32'(inst_req), 32'd0);
    wait_pop(pc, ins, adel);
    check("adel_pc", pc, 32'h80000102);
    check("adel_flag", 32'(adel), 32'd1);
    check("adel_instr", ins, 32'h0);
    step(3);
    check("adel_stop_req", 32'(inst_req), 32'd0);
    check("adel_single", 32'(id_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000200;
    step(1);
    redirect_valid = 1'b0;
    sb_q.delete();
    wait_pop(pc, ins, adel);
    check("resume_pc", pc, 32'h80000200);
    // Back-pressure on the request channel
    aok_en = 1'b0;
    step(6);
    a0 = inst_addr;
    for (int i = 0; i < 5; i++) begin
      check("hold_req", 32'(inst_req), 32'd1);
      check("hold_addr", inst_addr, a0);
      step(1);
    end
    aok_en = 1'b1;
    step(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
